perf_event_monitor: RTL and testbench
=====================================

// Module: perf_event_monitor
// PURPOSE
//  Synthesizable, parametrised performance monitor for the pipelined core; successor to the bench-only counting/trace logic.
//  Counts cycles, retired instructions and NUM_CH cache/pipeline event channels, then freezes the counters on halt.
//  Buffers retired PCs in a trace FIFO with valid/ready drain. Counters are read through a registered select port.
// PARAMETERS
//  NUM_CH      4   event channels (ch0 ICacheReq, ch1 ICacheHit, ch2 DCacheReq, ch3 DCacheHit by convention)
//  CNT_W       32  width of every counter
//  SAT         1   1: counters saturate at all-ones; 0: counters wrap modulo 2^CNT_W
//  FIFO_DEPTH  8   trace FIFO entries; power of 2, >=2
//  PC_W        16  traced PC width
//  SEL_W       $clog2(NUM_CH+3)  derived; width of rd_sel
// PORTS
//  clk        in   1          clock, all logic on posedge
//  rst        in   1          synchronous reset, active-low (0 = reset)
//  en         in   1          counting enable
//  clr        in   1          synchronous clear: counters, FIFO and FSM
//  ev         in   NUM_CH     per-channel event strobe, one count per cycle high
//  retire     in   1          one instruction commits this cycle (RegWrite|MemWrite)
//  retire_pc  in   PC_W       PC of the committing instruction
//  halt       in   1          halt instruction commits this cycle
//  rd_sel     in   SEL_W      counter select
//  rd_data    out  CNT_W      selected counter, registered
//  tr_valid   out  1          FIFO non-empty
//  tr_ready   in   1          sink accepts tr_pc
//  tr_pc      out  PC_W       FIFO head (fall-through)
//  halted     out  1          FSM in FROZEN or DONE
//  done       out  1          FSM in DONE
// BEHAVIOUR
//  Reset (rst=0 at posedge): all counters 0, FIFO empty, FSM IDLE; rd_data=0, tr_valid=0, tr_pc=0, halted=0, done=0.
//  FSM:
//   IDLE   -> RUN    when en=1
//   RUN    -> IDLE   when en=0
//   RUN    -> FROZEN when halt=1
//   FROZEN -> DONE   when FIFO is empty and no pop occurs that cycle
//   DONE   holds until clr or rst
//  Counting is active only in a cycle that starts in RUN, including the cycle in which halt is seen:
//   cycle_cnt += 1; inst_cnt += (retire|halt); ev_cnt[i] += ev[i].
//  Counting is disabled in IDLE, FROZEN and DONE; counters hold their value.
//  Overflow: SAT=1 holds at 2^CNT_W-1; SAT=0 wraps to 0.
//  Trace push: in RUN when (retire|halt), push retire_pc.
//   Push when full and no pop in the same cycle -> entry dropped, drop_cnt += 1 (SAT rule applies).
//   Push when full with a pop in the same cycle -> push accepted, occupancy unchanged.
//   Pushes stop after RUN is left; the FIFO keeps draining in every state.
//  Trace pop: pop when tr_valid & tr_ready. tr_pc = head entry, or 0 when empty. Read/write pointers wrap at FIFO_DEPTH.
//  Read map (1-cycle latency: rd_data at edge N+1 reflects rd_sel and counters at edge N):
//   0 cycle_cnt; 1 inst_cnt; 2 drop_cnt; 3..NUM_CH+2 ev_cnt[sel-3]; any other value reads 0.
//  clr=1 has priority over every other input except rst:
//   counters and drop_cnt -> 0, FIFO flushed, FSM -> IDLE, rd_data -> 0, all taking effect at the next edge.
//  rst or clr mid-operation, including while FROZEN with a non-empty FIFO, discards pending trace entries.
// TESTING
//  T1 reset: rst=0 for 3 cycles with ev=4'hF, retire=1 -> every rd_sel reads 0, tr_valid=0, halted=0.
//  T2 count: en=1 for 10 cycles, ev[0] high 5 cycles, retire 3 cycles -> sel0=10, sel1=3, sel3=5, sel4..6=0.
//  T3 overflow: CNT_W=4, ev[1] held 20 cycles -> sel4=15 with SAT=1; sel4=4 with SAT=0.
//  T4 FIFO: tr_ready=0, retire PCs 0x0002..0x0014 on 10 consecutive cycles, depth 8 -> sel2=2;
//     then tr_ready=1 -> tr_pc 0x0002..0x0010 in order, then tr_valid=0; full+pop in same cycle -> no drop.
//  T5 halt: retire+halt on cycle 6 -> sel1 includes the halt, halted=1 next cycle;
//     further ev/retire leave counters unchanged; done=1 only after FIFO drained.
//  T6 clr/rst mid-run: clr=1 in FROZEN with 3 FIFO entries -> tr_valid=0, all counters 0, FSM IDLE next cycle;
//     repeat with rst=0 -> same result.

Source files
------------

// File: rtl/perf_event_monitor.sv
// Performance monitor: cycle/retire/event counters, retired-PC trace FIFO, halt freeze FSM.
// Latency: counters update on the edge ending a RUN cycle; rd_data is registered one cycle after rd_sel.
// Backpressure: trace FIFO drains on tr_valid & tr_ready; a push into a full FIFO without a pop is dropped and counted.
module perf_event_monitor #(
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = 32,
   parameter int SAT        = 1,
   parameter int FIFO_DEPTH = 8,
   parameter int PC_W       = 16,
   parameter int SEL_W      = $clog2(NUM_CH + 3)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic [NUM_CH-1:0] ev,
   input  logic              retire,
   input  logic [PC_W-1:0]   retire_pc,
   input  logic              halt,
   input  logic [SEL_W-1:0]  rd_sel,
   output logic [CNT_W-1:0]  rd_data,
   output logic              tr_valid,
   input  logic              tr_ready,
   output logic [PC_W-1:0]   tr_pc,
   output logic              halted,
   output logic              done
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, FROZEN, DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cycle_cnt, inst_cnt, drop_cnt;
   logic [CNT_W-1:0] ev_cnt [NUM_CH];
   logic [PC_W-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [OCC_W-1:0] occ;
   logic             flush, counting, commit;
   logic             fifo_empty, fifo_full, pop, push, push_ok, drop;
   logic [CNT_W-1:0] rd_mux;

   // Increment by one when inc is set, holding at all-ones in saturating builds.
   function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic inc);
      logic [CNT_W-1:0] r;
      r = v;
      if (inc && !((SAT != 0) && (&v)))
         r = v + CNT_W'(1);
      return r;
   endfunction

   // Shared control terms: clear/reset priority, counting window, FIFO push/pop decisions.
   always_comb begin
      flush      = !rst || clr;
      counting   = (state == RUN);
      commit     = retire || halt;
      fifo_empty = (occ == '0);
      fifo_full  = (occ == OCC_W'(FIFO_DEPTH));
      pop        = !fifo_empty && tr_ready;
      push       = counting && commit;
      push_ok    = push && (!fifo_full || pop);
      drop       = push && fifo_full && !pop;
      tr_valid   = !fifo_empty;
      tr_pc      = fifo_empty ? '0 : mem[rd_ptr];
      halted     = (state == FROZEN) || (state == DONE);
      done       = (state == DONE);
   end

   // Next-state logic; halt wins over en dropping in the same RUN cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = RUN;
         RUN:     if (halt) state_nxt = FROZEN;
                  else if (!en) state_nxt = IDLE;
         FROZEN:  if (fifo_empty && !pop) state_nxt = DONE;
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (flush) state <= IDLE;
      else       state <= state_nxt;
   end

   // Event counters advance only in cycles that start in RUN; drops can only occur then too.
   always_ff @(posedge clk) begin
      if (flush) begin
         cycle_cnt <= '0;
         inst_cnt  <= '0;
         drop_cnt  <= '0;
         for (int i = 0; i < NUM_CH; i++) ev_cnt[i] <= '0;
      end else begin
         drop_cnt <= bump(drop_cnt, drop);
         if (counting) begin
            cycle_cnt <= bump(cycle_cnt, 1'b1);
            inst_cnt  <= bump(inst_cnt, commit);
            for (int i = 0; i < NUM_CH; i++) ev_cnt[i] <= bump(ev_cnt[i], ev[i]);
         end
      end
   end

   // Trace FIFO storage; contents need no reset since occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (!flush && push_ok) mem[wr_ptr] <= retire_pc;
   end

   // Trace FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk) begin
      if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_ok && !pop)      occ <= occ + OCC_W'(1);
         else if (!push_ok && pop) occ <= occ - OCC_W'(1);
      end
   end

   // Read map: 0 cycles, 1 instructions, 2 drops, 3.. event channels, anything else 0.
   always_comb begin
      rd_mux = '0;
      case (rd_sel)
         SEL_W'(0): rd_mux = cycle_cnt;
         SEL_W'(1): rd_mux = inst_cnt;
         SEL_W'(2): rd_mux = drop_cnt;
         default: begin
            for (int i = 0; i < NUM_CH; i++)
               if (rd_sel == SEL_W'(i + 3)) rd_mux = ev_cnt[i];
         end
      endcase
   end

   // Registered read port.
   always_ff @(posedge clk) begin
      if (flush) rd_data <= '0;
      else       rd_data <= rd_mux;
   end

endmodule

// File: tb/tb_perf_event_monitor.sv
// Bench for perf_event_monitor: a wide saturating DUT plus 4-bit saturating and wrapping copies on shared stimulus.
// Latency: expectations are tagged with the edge they apply to and checked 3 time units after that edge.
// Backpressure: trace pops are scored against a queue of accepted PCs whenever tr_valid & tr_ready is seen.
module tb_perf_event_monitor;
   localparam int NCH   = 4;
   localparam int PCW   = 16;
   localparam int SELW  = 3;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, en, clr, retire, halt, tr_ready;
   logic [NCH-1:0]  ev;
   logic [PCW-1:0]  retire_pc;
   logic [SELW-1:0] rd_sel;
   logic [31:0]     rd_data;
   logic [3:0]      rd_s, rd_w;
   logic            tr_valid, halted, done;
   logic            tv_s, tv_w, h_s, h_w, d_s, d_w;
   logic [PCW-1:0]  tr_pc, tp_s, tp_w;

   perf_event_monitor #(.NUM_CH(NCH), .CNT_W(32), .SAT(1), .FIFO_DEPTH(DEPTH), .PC_W(PCW)) u_dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .ev(ev), .retire(retire), .retire_pc(retire_pc),
      .halt(halt), .rd_sel(rd_sel), .rd_data(rd_data), .tr_valid(tr_valid), .tr_ready(tr_ready),
      .tr_pc(tr_pc), .halted(halted), .done(done));

   perf_event_monitor #(.NUM_CH(NCH), .CNT_W(4), .SAT(1), .FIFO_DEPTH(DEPTH), .PC_W(PCW)) u_sat (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .ev(ev), .retire(retire), .retire_pc(retire_pc),
      .halt(halt), .rd_sel(rd_sel), .rd_data(rd_s), .tr_valid(tv_s), .tr_ready(tr_ready),
      .tr_pc(tp_s), .halted(h_s), .done(d_s));

   perf_event_monitor #(.NUM_CH(NCH), .CNT_W(4), .SAT(0), .FIFO_DEPTH(DEPTH), .PC_W(PCW)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .ev(ev), .retire(retire), .retire_pc(retire_pc),
      .halt(halt), .rd_sel(rd_sel), .rd_data(rd_w), .tr_valid(tv_w), .tr_ready(tr_ready),
      .tr_pc(tp_w), .halted(h_w), .done(d_w));

   typedef struct {
      int             tgt;
      logic [31:0]    rd32;
      logic [3:0]     rds;
      logic [3:0]     rdw;
      logic           vld;
      logic           hlt;
      logic           dn;
      logic [PCW-1:0] pc;
   } exp_t;

   int unsigned    checks = 0;
   int unsigned    errors = 0;
   int             edge_no = 0;
   exp_t           exp_q[$];
   logic [PCW-1:0] exp_tr[$];

   // Reference model: unbounded true counts, phase 0 idle / 1 run / 2 frozen / 3 done, FIFO as a queue.
   longint         m_cyc, m_inst, m_drop;
   longint         m_ev[NCH];
   int             m_phase;
   logic [PCW-1:0] m_fifo[$];

   function automatic logic [31:0] lim(input longint v, input int w, input bit sat);
      longint mx;
      mx = (longint'(1) << w) - 1;
      if (sat) return (v > mx) ? 32'(mx) : 32'(v);
      return 32'(v & mx);
   endfunction

   function automatic longint model_read(input int sel);
      if (sel == 0) return m_cyc;
      if (sel == 1) return m_inst;
      if (sel == 2) return m_drop;
      if (sel >= 3 && sel < 3 + NCH) return m_ev[sel - 3];
      return 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s edge=%0d actual=%0h expected=%0h", name, edge_no, act, expv);
      end
   endtask

   // One clock of stimulus: drive inputs, advance the model, queue the post-edge expectation.
   task automatic step(input logic r, input logic c, input logic e, input logic [NCH-1:0] evv,
                       input logic rt, input logic [PCW-1:0] pc, input logic h, input logic rdy,
                       input int sel);
      exp_t   x;
      longint v;
      int     occ;
      bit     pop, run, rdy_eff;
      rdy_eff   = rdy && r && !c;
      rst       = r;   clr    = c;   en   = e;  ev       = evv;
      retire    = rt;  retire_pc = pc; halt = h; tr_ready = rdy_eff;
      rd_sel    = SELW'(sel);
      if (!r || c) begin
         x.rd32 = 0; x.rds = 0; x.rdw = 0;
         m_cyc = 0; m_inst = 0; m_drop = 0;
         for (int i = 0; i < NCH; i++) m_ev[i] = 0;
         m_fifo.delete();
         exp_tr.delete();
         m_phase = 0;
      end else begin
         v      = model_read(sel);
         x.rd32 = lim(v, 32, 1'b1);
         x.rds  = 4'(lim(v, 4, 1'b1));
         x.rdw  = 4'(lim(v, 4, 1'b0));
         occ    = m_fifo.size();
         pop    = (occ > 0) && rdy_eff;
         run    = (m_phase == 1);
         if (run) begin
            m_cyc++;
            if (rt || h) m_inst++;
            for (int i = 0; i < NCH; i++) if (evv[i]) m_ev[i]++;
         end
         if (pop) m_fifo.delete(0);
         if (run && (rt || h)) begin
            if (occ == DEPTH && !pop) m_drop++;
            else begin
               m_fifo.push_back(pc);
               exp_tr.push_back(pc);
            end
         end
         case (m_phase)
            0: if (e) m_phase = 1;
            1: if (h) m_phase = 2; else if (!e) m_phase = 0;
            2: if (occ == 0) m_phase = 3;
            default: ;
         endcase
      end
      x.tgt = edge_no + 1;
      x.vld = (m_fifo.size() != 0);
      x.pc  = x.vld ? m_fifo[0] : '0;
      x.hlt = (m_phase >= 2);
      x.dn  = (m_phase == 3);
      exp_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cyc(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1, 0, 0, '0, 0, '0, 0, rdy, $urandom_range(0, 7));
   endtask

   task automatic sweep();
      for (int s = 0; s < 8; s++) step(1, 0, 0, '0, 0, '0, 0, 1'b1, s);
   endtask

   task automatic do_clr();
      step(1, 1, 0, '0, 0, '0, 0, 1'b0, 0);
   endtask

   // Monitor: score per-edge state and every trace handshake the DUT presents.
   always @(posedge clk) begin
      exp_t x;
      edge_no++;
      #3;
      if (exp_q.size() > 0 && exp_q[0].tgt == edge_no) begin
         x = exp_q.pop_front();
         chk("rd_data",      rd_data,  x.rd32);
         chk("rd_data_sat4", 32'(rd_s), 32'(x.rds));
         chk("rd_data_wrap4",32'(rd_w), 32'(x.rdw));
         chk("tr_valid",     32'(tr_valid), 32'(x.vld));
         chk("tr_pc",        32'(tr_pc),    32'(x.pc));
         chk("halted",       32'(halted),   32'(x.hlt));
         chk("done",         32'(done),     32'(x.dn));
         chk("tr_valid_sat4",32'(tv_s),     32'(x.vld));
         chk("tr_valid_wrap4",32'(tv_w),    32'(x.vld));
         chk("halted_narrow",32'({h_s, h_w}), 32'({x.hlt, x.hlt}));
         chk("done_narrow",  32'({d_s, d_w}), 32'({x.dn, x.dn}));
         chk("tr_pc_narrow", 32'(tp_s ^ tp_w), 32'(0));
      end
      if (tr_valid === 1'b1 && tr_ready === 1'b1) begin
         if (exp_tr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL trace_pop edge=%0d actual=%0h expected=none", edge_no, tr_pc);
         end else begin
            chk("trace_pop", 32'(tr_pc), 32'(exp_tr.pop_front()));
         end
      end
   end

   initial begin
      int wait_cnt;
      rst = 1'b0; clr = 1'b0; en = 1'b0; ev = '0; retire = 1'b0; retire_pc = '0;
      halt = 1'b0; tr_ready = 1'b0; rd_sel = '0;
      m_cyc = 0; m_inst = 0; m_drop = 0; m_phase = 0;
      for (int i = 0; i < NCH; i++) m_ev[i] = 0;
      @(posedge clk);
      #1;

      // T1: reset with activity on every input, reading every select.
      for (int s = 0; s < 8; s++) step(0, 0, 1, 4'hF, 1, 16'h1234, 0, 1, s);

      // T2: 10 enabled cycles, ev[0] for 5, retire for 3.
      for (int i = 0; i < 10; i++)
         step(1, 0, 1, {3'b000, (i >= 2 && i < 7)}, (i >= 3 && i < 6), PCW'(i * 4), 0, 1, 0);
      step(1, 0, 0, '0, 0, '0, 0, 1, 0);
      sweep();

      // T3: ev[1] held 20 counting cycles to overflow the 4-bit copies.
      do_clr();
      for (int i = 0; i < 21; i++)
         step(1, 0, 1, 4'b0010, 1'($urandom), PCW'($urandom), 0, 1, $urandom_range(0, 7));
      step(1, 0, 0, '0, 0, '0, 0, 1, 0);
      sweep();

      // T4: ten retires into a stalled depth-8 FIFO, drain, then full with simultaneous pop.
      do_clr();
      step(1, 0, 1, '0, 0, '0, 0, 0, 2);
      for (int i = 0; i < 10; i++) step(1, 0, 1, '0, 1, PCW'(2 + 2 * i), 0, 0, 2);
      for (int i = 0; i < 10; i++) step(1, 0, 1, '0, 0, '0, 0, 1, 2);
      for (int i = 0; i < 8; i++)  step(1, 0, 1, '0, 1, PCW'(16'h100 + i), 0, 0, 2);
      step(1, 0, 1, '0, 1, 16'h0200, 0, 1, 2);
      step(1, 0, 0, '0, 0, '0, 0, 1, 2);
      idle_cyc(10, 1'b1);
      sweep();

      // T5: halt with retire on cycle 6, frozen activity, then drain to done.
      do_clr();
      step(1, 0, 1, '0, 0, '0, 0, 0, 1);
      for (int i = 0; i < 5; i++)
         step(1, 0, 1, NCH'($urandom), 1'($urandom), PCW'($urandom), 0, 0, $urandom_range(0, 7));
      step(1, 0, 1, 4'h5, 1, 16'hBEEF, 1, 0, 1);
      for (int i = 0; i < 6; i++)
         step(1, 0, 1, NCH'($urandom), 1'($urandom), PCW'($urandom), 0, 0, $urandom_range(0, 7));
      for (int i = 0; i < 12; i++)
         step(1, 0, 1, NCH'($urandom), 1'($urandom), PCW'($urandom), 0, 1, $urandom_range(0, 7));
      sweep();

      // T6: clear, then reset, while frozen with three pending entries.
      for (int k = 0; k < 2; k++) begin
         do_clr();
         step(1, 0, 1, '0, 0, '0, 0, 0, 0);
         step(1, 0, 1, 4'h3, 1, 16'h0A00, 0, 0, 0);
         step(1, 0, 1, 4'h3, 1, 16'h0A02, 0, 0, 0);
         step(1, 0, 1, 4'h3, 1, 16'h0A04, 1, 0, 0);
         step(1, 0, 1, 4'h3, 1, 16'h0A06, 0, 0, 1);
         if (k == 0) step(1, 1, 1, 4'hF, 1, 16'h0A08, 0, 1, 1);
         else        step(0, 0, 1, 4'hF, 1, 16'h0A08, 0, 1, 1);
         sweep();
      end

      // Random soak.
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
              NCH'($urandom), 1'($urandom), PCW'($urandom), ($urandom_range(0, 39) == 0),
              1'($urandom), $urandom_range(0, 7));
      idle_cyc(4, 1'b1);

      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 20) begin
         @(posedge clk);
         #5;
         wait_cnt++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
